// File: rtl/ann_pkg.sv
// Shared ANN constants: RAM geometry plus the RAM requester map.
package ann_pkg;

    localparam int ADDR_WIDTH = 10;
    localparam int RAM_WORDS  = 1 << ADDR_WIDTH;
    localparam int RAM_PORT   = 16;

    localparam int N_RAM_REQ     = 3;
    localparam int RAM_MAX_BURST = 8;

    localparam int REQ_WLOAD  = 0;
    localparam int REQ_ENGINE = 1;
    localparam int REQ_HOST   = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority pick: the search starts one past ptr_i.
module rr_arbiter #(
    parameter int N = 3,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = PW'((int'(ptr_i) + i) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ann_ram_arbiter.sv
// Single-port ANN RAM arbiter: round-robin grant, bounded burst lock,
// read data routed back to the issuing requester one cycle later.
module ann_ram_arbiter
    import ann_pkg::*;
#(
    parameter int N_REQ     = N_RAM_REQ,
    parameter int ADDR_W    = ADDR_WIDTH,
    parameter int DATA_W    = RAM_PORT,
    parameter int MAX_BURST = RAM_MAX_BURST
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic [N_REQ-1:0]               req_valid_i,
    output logic [N_REQ-1:0]               req_ready_o,
    input  logic [N_REQ-1:0]               req_we_i,
    input  logic [N_REQ-1:0]               req_lock_i,
    input  logic [N_REQ-1:0][ADDR_W-1:0]   req_addr_i,
    input  logic [N_REQ-1:0][DATA_W-1:0]   req_wdata_i,
    output logic [N_REQ-1:0]               rsp_valid_o,
    output logic [DATA_W-1:0]              rsp_data_o,
    output logic                           ram_we_o,
    output logic [ADDR_W-1:0]              ram_addr_o,
    output logic [DATA_W-1:0]              ram_wdata_o,
    input  logic [DATA_W-1:0]              ram_rdata_i
);

    localparam int          PW    = $clog2(N_REQ);
    localparam logic [7:0]  MAX_B = 8'(MAX_BURST);

    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [PW-1:0]     rd_owner_q, rd_owner_d;
    logic              lock_q, lock_d;
    logic              rd_pend_q, rd_pend_d;
    logic [7:0]        burst_q, burst_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [N_REQ-1:0]  rr_gnt;
    logic [N_REQ-1:0]  gnt;
    logic [PW-1:0]     gnt_idx;
    logic              lock_hold;
    logic              beat;
    logic [7:0]        burst_nxt;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (rr_gnt)
    );

    assign lock_hold = lock_q & req_valid_i[owner_q];

    always_comb begin
        gnt = rr_gnt;
        if (lock_hold) begin
            gnt          = '0;
            gnt[owner_q] = 1'b1;
        end
        if (rst_n_i) begin
            gnt = '0;
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = PW'(i);
            end
        end
    end

    assign beat = |gnt;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        rd_owner_d = rd_owner_q;
        lock_d     = lock_q;
        rd_pend_d  = 1'b0;
        burst_d    = burst_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        // a continuing burst counts on; a fresh lock starts at one beat
        burst_nxt  = (lock_hold ? burst_q : 8'd0) + 8'd1;

        if (lock_q && !req_valid_i[owner_q]) begin
            lock_d  = 1'b0;
            burst_d = 8'd0;
        end

        if (beat) begin
            rr_ptr_d = gnt_idx;
            addr_d   = req_addr_i[gnt_idx];
            wdata_d  = req_wdata_i[gnt_idx];
            if (!req_we_i[gnt_idx]) begin
                rd_pend_d  = 1'b1;
                rd_owner_d = gnt_idx;
            end
            if (req_lock_i[gnt_idx] && (burst_nxt < MAX_B)) begin
                lock_d  = 1'b1;
                owner_d = gnt_idx;
                burst_d = burst_nxt;
            end else begin
                lock_d  = 1'b0;
                burst_d = 8'd0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_n_i) begin
        if (rst_n_i) begin
            rr_ptr_q   <= PW'(N_REQ - 1);
            owner_q    <= '0;
            rd_owner_q <= '0;
            lock_q     <= 1'b0;
            rd_pend_q  <= 1'b0;
            burst_q    <= 8'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            rd_owner_q <= rd_owner_d;
            lock_q     <= lock_d;
            rd_pend_q  <= rd_pend_d;
            burst_q    <= burst_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign req_ready_o = gnt;
    assign ram_we_o    = beat & req_we_i[gnt_idx];
    assign ram_addr_o  = beat ? req_addr_i[gnt_idx] : addr_q;
    assign ram_wdata_o = beat ? req_wdata_i[gnt_idx] : wdata_q;

    always_comb begin
        rsp_valid_o = '0;
        if (rd_pend_q) begin
            rsp_valid_o[rd_owner_q] = 1'b1;
        end
    end

    assign rsp_data_o = ram_rdata_i;

endmodule

// File: tb/tb_ann_ram_arbiter.sv
// Directed bench for ann_ram_arbiter with a RAM model and a response scoreboard.
module tb_ann_ram_arbiter;
    import ann_pkg::*;

    localparam int N  = N_RAM_REQ;
    localparam int AW = ADDR_WIDTH;
    localparam int DW = RAM_PORT;

    logic                   clk_i = 1'b0;
    logic                   rst_n_i = 1'b1;
    logic [N-1:0]           req_valid_i;
    logic [N-1:0]           req_ready_o;
    logic [N-1:0]           req_we_i;
    logic [N-1:0]           req_lock_i;
    logic [N-1:0][AW-1:0]   req_addr_i;
    logic [N-1:0][DW-1:0]   req_wdata_i;
    logic [N-1:0]           rsp_valid_o;
    logic [DW-1:0]          rsp_data_o;
    logic                   ram_we_o;
    logic [AW-1:0]          ram_addr_o;
    logic [DW-1:0]          ram_wdata_o;
    logic [DW-1:0]          ram_rdata_i;

    typedef struct {
        int            owner;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          rsp_q[$];
    logic [DW-1:0] mem[int];
    logic [DW-1:0] shadow[int];
    logic [AW-1:0] a[N];
    logic [DW-1:0] d[N];
    logic [AW-1:0] last_addr;
    int            n_cmp = 0;
    int            n_err = 0;

    ann_ram_arbiter dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_lock_i  (req_lock_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [DW-1:0] seed(input logic [AW-1:0] ad);
        return DW'(32'(ad) * 3 + 263);
    endfunction

    always @(posedge clk_i) begin
        if (ram_we_o) begin
            mem[int'(ram_addr_o)] = ram_wdata_o;
        end else begin
            ram_rdata_i <= mem.exists(int'(ram_addr_o)) ?
                           mem[int'(ram_addr_o)] : seed(ram_addr_o);
        end
    end

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] ad);
        return shadow.exists(int'(ad)) ? shadow[int'(ad)] : seed(ad);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp(input string tag);
        rsp_t e;
        if (rsp_q.size() > 0) begin
            e = rsp_q.pop_front();
            chk({tag, "/rsp_valid"}, 32'(rsp_valid_o), 32'(1) << e.owner);
            chk({tag, "/rsp_data"}, 32'(rsp_data_o), 32'(e.data));
        end else begin
            chk({tag, "/rsp_idle"}, 32'(rsp_valid_o), 32'd0);
        end
    endtask

    task automatic step(input logic [N-1:0] v, input logic [N-1:0] we,
                        input logic [N-1:0] lk, input int g,
                        input string tag);
        @(negedge clk_i);
        check_rsp(tag);
        req_valid_i = v;
        req_we_i    = we;
        req_lock_i  = lk;
        for (int i = 0; i < N; i++) begin
            req_addr_i[i]  = a[i];
            req_wdata_i[i] = d[i];
        end
        #1;
        if (g < 0) begin
            chk({tag, "/ready"}, 32'(req_ready_o), 32'd0);
            chk({tag, "/ram_we"}, 32'(ram_we_o), 32'd0);
            chk({tag, "/addr_hold"}, 32'(ram_addr_o), 32'(last_addr));
        end else begin
            chk({tag, "/ready"}, 32'(req_ready_o), 32'(1) << g);
            chk({tag, "/ram_we"}, 32'(ram_we_o), 32'(we[g]));
            chk({tag, "/ram_addr"}, 32'(ram_addr_o), 32'(a[g]));
            last_addr = a[g];
            if (we[g]) begin
                chk({tag, "/ram_wdata"}, 32'(ram_wdata_o), 32'(d[g]));
                shadow[int'(a[g])] = d[g];
            end else begin
                rsp_q.push_back('{owner: g, data: exp_rd(a[g])});
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            a[i] = AW'(10 + i);
            d[i] = DW'(16'h1000 + i);
        end
        last_addr   = '0;
        req_valid_i = '1;
        req_we_i    = '1;
        req_lock_i  = '0;
        req_addr_i  = '0;
        req_wdata_i = '0;

        #2;
        chk("reset/ready", 32'(req_ready_o), 32'd0);
        chk("reset/ram_we", 32'(ram_we_o), 32'd0);
        chk("reset/rsp_valid", 32'(rsp_valid_o), 32'd0);
        req_valid_i = '0;
        @(negedge clk_i);
        rst_n_i = 1'b0;

        // round robin with everybody asking
        step(3'b111, 3'b101, 3'b000, 0, "rr0");
        step(3'b111, 3'b101, 3'b000, 1, "rr1");
        step(3'b111, 3'b101, 3'b000, 2, "rr2");
        step(3'b111, 3'b101, 3'b000, 0, "rr3");

        // write then read-back of the same word
        a[1] = AW'(5);
        d[1] = DW'(16'h00A5);
        step(3'b010, 3'b010, 3'b000, 1, "raw_wr");
        a[2] = AW'(5);
        step(3'b100, 3'b000, 3'b000, 2, "raw_rd");
        step(3'b000, 3'b000, 3'b000, -1, "raw_idle");

        // bounded burst: eight locked beats, then the other requester
        a[1] = AW'(11);
        for (int i = 0; i < 8; i++) begin
            a[0] = AW'(20 + i);
            step(3'b011, 3'b000, 3'b001, 0, $sformatf("burst%0d", i));
        end
        step(3'b011, 3'b000, 3'b001, 1, "burst_end");
        step(3'b000, 3'b000, 3'b000, -1, "burst_idle");

        // lock holds against round robin, drop of valid releases it
        a[0] = AW'(30);
        a[2] = AW'(31);
        step(3'b001, 3'b000, 3'b001, 0, "lock_a");
        step(3'b101, 3'b000, 3'b001, 0, "lock_hold");
        step(3'b100, 3'b000, 3'b001, 2, "lock_drop");
        step(3'b000, 3'b000, 3'b000, -1, "lock_idle");

        // back-to-back reads from different requesters
        a[0] = AW'(1);
        a[1] = AW'(2);
        step(3'b001, 3'b000, 3'b000, 0, "b2b_0");
        step(3'b010, 3'b000, 3'b000, 1, "b2b_1");
        step(3'b000, 3'b000, 3'b000, -1, "b2b_idle");

        // reset right after a read issue
        a[0] = AW'(3);
        step(3'b001, 3'b000, 3'b000, 0, "mid_rd");
        @(negedge clk_i);
        rst_n_i     = 1'b1;
        req_valid_i = '1;
        req_we_i    = '1;
        #1;
        chk("mid_rst/rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("mid_rst/ready", 32'(req_ready_o), 32'd0);
        chk("mid_rst/ram_we", 32'(ram_we_o), 32'd0);
        rsp_q.delete();
        req_valid_i = '0;
        @(negedge clk_i);
        rst_n_i = 1'b0;
        a[0] = AW'(40);
        a[1] = AW'(41);
        a[2] = AW'(42);
        step(3'b111, 3'b000, 3'b000, 0, "post_rst");
        step(3'b000, 3'b000, 3'b000, -1, "final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
